// File: rtl/hc595_pkg.sv
// Shared types and sizing helpers for the 74HC595 chain controller.
// Transfer latency helper: accept cycle to done cycle.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } hc595_state_t;

  function automatic int hc595_width(input int n);
    return 8 * n;
  endfunction

  function automatic int hc595_latency(input int n, input int div);
    return 2 * div * hc595_width(n) + div + 1;
  endfunction

endpackage

// File: rtl/hc595_clk_div.sv
// Phase timer: phase_end strobes on every DIV-th cycle, 0-cycle latency from the count.
// No backpressure; restart holds the count at zero so each phase starts aligned.
module hc595_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic sclr,
  input  logic restart,
  output logic phase_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (sclr || restart) begin
      cnt <= '0;
    end else if (phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hc595_chain_ctrl.sv
// 74HC595 daisy-chain master: accept-to-done 2*DIV*W+DIV+1 cycles; wr_ready only in IDLE.
// Optional HC595_LOOPBACK_CHECK_EN adds a sticky chk_err readback compare.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int N       = 6,
  parameter int DIV     = 4,
  parameter int REFRESH = 0
) (
  input  logic           clk,
  input  logic           sclr,
  input  logic [8*N-1:0] wr_data,
  input  logic           wr_valid,
  output logic           wr_ready,
  output logic [8*N-1:0] rd_data,
  output logic           done,
  output logic           busy,
  output logic           sclk,
  output logic           sdo,
  output logic           lock,
  output logic           oe_n,
  input  logic           sdi
`ifdef HC595_LOOPBACK_CHECK_EN
  ,
  output logic           chk_err
`endif
);

  localparam int W  = hc595_width(N);
  localparam int BW = $clog2(W + 1);
  localparam int RW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;

  hc595_state_t state, state_next;

  logic         phase_end;
  logic         div_restart;
  logic         accept;
  logic         refresh_fire;
  logic         start;
  logic         last_bit;
  logic         sclk_next;
  logic         lock_next;
  logic         written;
  logic [W-1:0] tx_sr;
  logic [W-1:0] rx_sr;
  logic [W-1:0] last_word;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] timer;

  assign div_restart  = (state == IDLE);
  assign wr_ready     = (state == IDLE) && !sclr;
  assign accept       = wr_valid && wr_ready;
  assign refresh_fire = (REFRESH > 0) && (state == IDLE) && written &&
                        (timer == RW'(REFRESH)) && !sclr;
  assign start        = accept || refresh_fire;
  assign last_bit     = (bit_cnt == BW'(W - 1));
  assign busy         = (state != IDLE);
  // tx_sr zero-fills as it shifts, so sdo is already 0 in LATCH and IDLE.
  assign sdo          = tx_sr[W-1];

  hc595_clk_div #(.DIV(DIV)) u_clk_div (
    .clk       (clk),
    .sclr      (sclr),
    .restart   (div_restart),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start)     state_next = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_next = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (phase_end) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Chain strobes are decoded from the next state and registered to stay glitch-free.
  always_comb begin
    sclk_next = (state_next == SHIFT_HI);
    lock_next = (state_next == LATCH);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      sclk <= 1'b0;
      lock <= 1'b0;
    end else begin
      sclk <= sclk_next;
      lock <= lock_next;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      last_word <= '0;
      bit_cnt   <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      oe_n      <= 1'b1;
      written   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        tx_sr   <= accept ? wr_data : last_word;
        bit_cnt <= '0;
        if (accept) begin
          last_word <= wr_data;
          written   <= 1'b1;
        end
      end
      if ((state == SHIFT_LO) && phase_end) begin
        rx_sr <= {rx_sr[W-2:0], sdi};
      end
      if ((state == SHIFT_HI) && phase_end) begin
        tx_sr   <= {tx_sr[W-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if ((state == LATCH) && phase_end) begin
        done    <= 1'b1;
        rd_data <= rx_sr;
        oe_n    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr || start) begin
      timer <= '0;
    end else if ((REFRESH > 0) && (state == IDLE) && written && (timer != RW'(REFRESH))) begin
      timer <= timer + RW'(1);
    end
  end

`ifdef HC595_LOOPBACK_CHECK_EN
  logic [W-1:0] prev_word;
  logic         have_prev;

  // The chain returns what the previous transfer latched; the first one after reset is unknown.
  always_ff @(posedge clk) begin
    if (sclr) begin
      chk_err   <= 1'b0;
      prev_word <= '0;
      have_prev <= 1'b0;
    end else if ((state == LATCH) && phase_end) begin
      if (have_prev && (rx_sr != prev_word)) begin
        chk_err <= 1'b1;
      end
      prev_word <= last_word;
      have_prev <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Bench for hc595_chain_ctrl: behavioural 74HC595 chains close the loop on each instance.
// Define HC595_LOOPBACK_CHECK_EN to also exercise chk_err on a single-chip instance.
module tb_hc595_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: N=2, DIV=2, no refresh
  logic        a_sclr, a_wr_valid, a_wr_ready, a_done, a_busy, a_sclk, a_sdo, a_lock, a_oe_n, a_sdi;
  logic [15:0] a_wr_data, a_rd_data;
  logic        a_chk;
  logic [15:0] a_sr = '0;
  logic [15:0] a_q  = '0;
  int          a_lock_pulses = 0;

  always @(posedge a_sclk) a_sr <= {a_sr[14:0], a_sdo};
  always @(posedge a_lock) begin
    a_q           <= a_sr;
    a_lock_pulses <= a_lock_pulses + 1;
  end
  assign a_sdi = a_sr[15];

  hc595_chain_ctrl #(.N(2), .DIV(2), .REFRESH(0)) dut_a (
    .clk(clk), .sclr(a_sclr), .wr_data(a_wr_data), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .rd_data(a_rd_data), .done(a_done), .busy(a_busy), .sclk(a_sclk), .sdo(a_sdo),
    .lock(a_lock), .oe_n(a_oe_n), .sdi(a_sdi)
`ifdef HC595_LOOPBACK_CHECK_EN
    , .chk_err(a_chk)
`endif
  );

  // Instance B: N=6, DIV=1, REFRESH=10
  logic        b_sclr, b_wr_valid, b_wr_ready, b_done, b_busy, b_sclk, b_sdo, b_lock, b_oe_n, b_sdi;
  logic [47:0] b_wr_data, b_rd_data;
  logic        b_chk;
  logic [47:0] b_sr = '0;
  logic [47:0] b_q  = '0;
  int          b_lock_pulses = 0;

  always @(posedge b_sclk) b_sr <= {b_sr[46:0], b_sdo};
  always @(posedge b_lock) begin
    b_q           <= b_sr;
    b_lock_pulses <= b_lock_pulses + 1;
  end
  assign b_sdi = b_sr[47];

  hc595_chain_ctrl #(.N(6), .DIV(1), .REFRESH(10)) dut_b (
    .clk(clk), .sclr(b_sclr), .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .done(b_done), .busy(b_busy), .sclk(b_sclk), .sdo(b_sdo),
    .lock(b_lock), .oe_n(b_oe_n), .sdi(b_sdi)
`ifdef HC595_LOOPBACK_CHECK_EN
    , .chk_err(b_chk)
`endif
  );

`ifdef HC595_LOOPBACK_CHECK_EN
  // Instance C: N=1, DIV=1, chain return stuck at 0
  logic       c_sclr, c_wr_valid, c_wr_ready, c_done, c_busy, c_sclk, c_sdo, c_lock, c_oe_n, c_sdi, c_chk;
  logic [7:0] c_wr_data, c_rd_data;
  assign c_sdi = 1'b0;

  hc595_chain_ctrl #(.N(1), .DIV(1), .REFRESH(0)) dut_c (
    .clk(clk), .sclr(c_sclr), .wr_data(c_wr_data), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
    .rd_data(c_rd_data), .done(c_done), .busy(c_busy), .sclk(c_sclk), .sdo(c_sdo),
    .lock(c_lock), .oe_n(c_oe_n), .sdi(c_sdi), .chk_err(c_chk)
  );
`endif

  // Expected accept-to-done latencies: 2*DIV*W + DIV + 1
  localparam int LAT_A = 2 * 2 * 16 + 2 + 1;
  localparam int LAT_B = 2 * 1 * 48 + 1 + 1;

  logic [15:0] a_prev = '0;
  logic [15:0] a_snap;
  int          a_lat, a_lock_cyc, a_sclk_rise;
  logic        a_oe_before;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [15:0] w);
    int   n;
    logic prev_sclk;
    a_wr_data  = w;
    a_wr_valid = 1'b1;
    n = 0;
    while (a_wr_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    a_snap = a_sr;
    step();
    a_wr_valid  = 1'b0;
    a_lat       = 1;
    a_lock_cyc  = 0;
    a_sclk_rise = 0;
    prev_sclk   = a_sclk;
    a_oe_before = a_oe_n;
    while (a_done !== 1'b1 && a_lat < 2000) begin
      a_oe_before = a_oe_n;
      if (a_lock === 1'b1) a_lock_cyc++;
      if (a_sclk === 1'b1 && prev_sclk === 1'b0) a_sclk_rise++;
      prev_sclk = a_sclk;
      step();
      a_lat++;
    end
  endtask

  task automatic test_reset();
    a_sclr = 1'b1; b_sclr = 1'b1;
    a_wr_valid = 1'b0; b_wr_valid = 1'b0;
    a_wr_data = '0; b_wr_data = '0;
`ifdef HC595_LOOPBACK_CHECK_EN
    c_sclr = 1'b1; c_wr_valid = 1'b0; c_wr_data = '0;
`endif
    step(); step();
    a_sclr = 1'b0; b_sclr = 1'b0;
`ifdef HC595_LOOPBACK_CHECK_EN
    c_sclr = 1'b0;
`endif
    #1;
    tests_run++; if (a_sclk !== 1'b0) begin tests_failed++; $display("FAIL rst_sclk: got %b want 0", a_sclk); end
    tests_run++; if (a_lock !== 1'b0) begin tests_failed++; $display("FAIL rst_lock: got %b want 0", a_lock); end
    tests_run++; if (a_sdo !== 1'b0) begin tests_failed++; $display("FAIL rst_sdo: got %b want 0", a_sdo); end
    tests_run++; if (a_oe_n !== 1'b1) begin tests_failed++; $display("FAIL rst_oe_n: got %b want 1", a_oe_n); end
    tests_run++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_done_busy: got %b%b want 00", a_done, a_busy); end
    tests_run++; if (a_wr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_wr_ready: got %b want 1", a_wr_ready); end
    tests_run++; if (a_rd_data !== 16'h0) begin tests_failed++; $display("FAIL rst_rd_data: got %h want 0000", a_rd_data); end
    tests_run++; if (b_wr_ready !== 1'b1 || b_oe_n !== 1'b1) begin tests_failed++; $display("FAIL rst_b: got rdy=%b oe_n=%b want 1 1", b_wr_ready, b_oe_n); end
  endtask

  task automatic test_basic();
    write_a(16'hA5C3);
    tests_run++; if (a_lat != LAT_A) begin tests_failed++; $display("FAIL basic_latency: got %0d want %0d", a_lat, LAT_A); end
    tests_run++; if (a_q !== 16'hA5C3) begin tests_failed++; $display("FAIL basic_q: got %h want a5c3", a_q); end
    tests_run++; if (a_rd_data !== 16'h0000) begin tests_failed++; $display("FAIL basic_rd: got %h want 0000", a_rd_data); end
    tests_run++; if (a_oe_before !== 1'b1 || a_oe_n !== 1'b0) begin tests_failed++; $display("FAIL basic_oe_n: got before=%b at_done=%b want 1 0", a_oe_before, a_oe_n); end
    tests_run++; if (a_lock_cyc != 2) begin tests_failed++; $display("FAIL basic_lock_width: got %0d want 2", a_lock_cyc); end
    tests_run++; if (a_sclk_rise != 16) begin tests_failed++; $display("FAIL basic_sclk_edges: got %0d want 16", a_sclk_rise); end
    step();
    tests_run++; if (a_done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b want 0", a_done); end
    a_prev = 16'hA5C3;
  endtask

  task automatic test_back_to_back();
    int n;
    a_wr_data  = 16'h1234;
    a_wr_valid = 1'b1;
    n = 0;
    while (a_wr_ready !== 1'b1 && n < 2000) begin step(); n++; end
    step();
    a_wr_data = 16'hFFFF;
    n = 1;
    while (a_done !== 1'b1 && n < 2000) begin step(); n++; end
    tests_run++; if (n != LAT_A) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d want %0d", n, LAT_A); end
    tests_run++; if (a_rd_data !== a_prev) begin tests_failed++; $display("FAIL b2b_first_rd: got %h want %h", a_rd_data, a_prev); end
    tests_run++; if (a_wr_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_at_done: got %b want 1", a_wr_ready); end
    step();
    a_wr_valid = 1'b0;
    tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_single_idle: busy got %b want 1", a_busy); end
    n = 1;
    while (a_done !== 1'b1 && n < 2000) begin step(); n++; end
    tests_run++; if (n != LAT_A) begin tests_failed++; $display("FAIL b2b_done_to_done: got %0d want %0d", n, LAT_A); end
    tests_run++; if (a_rd_data !== 16'h1234) begin tests_failed++; $display("FAIL b2b_second_rd: got %h want 1234", a_rd_data); end
    tests_run++; if (a_q !== 16'hFFFF) begin tests_failed++; $display("FAIL b2b_second_q: got %h want ffff", a_q); end
    a_prev = 16'hFFFF;
  endtask

  task automatic test_random();
    logic [15:0] w;
    int gap;
    for (int i = 0; i < 6; i++) begin
      w   = 16'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      write_a(w);
      tests_run++; if (a_lat != LAT_A) begin tests_failed++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, a_lat, LAT_A); end
      tests_run++; if (a_q !== w) begin tests_failed++; $display("FAIL rand_q[%0d]: got %h want %h", i, a_q, w); end
      tests_run++; if (a_rd_data !== a_prev) begin tests_failed++; $display("FAIL rand_rd[%0d]: got %h want %h", i, a_rd_data, a_prev); end
      a_prev = w;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w, w2;
    int n, pulses_before;
    w = 16'($urandom) | 16'h0400;
    a_wr_data  = w;
    a_wr_valid = 1'b1;
    n = 0;
    while (a_wr_ready !== 1'b1 && n < 2000) begin step(); n++; end
    step();
    a_wr_valid = 1'b0;
    // bit 5 occupies cycles accept+21..accept+24; stop inside its low phase
    for (int k = 0; k < 21; k++) step();
    pulses_before = a_lock_pulses;
    a_sclr = 1'b1;
    step();
    a_sclr = 1'b0;
    #1;
    tests_run++; if (a_sclk !== 1'b0 || a_lock !== 1'b0 || a_sdo !== 1'b0) begin tests_failed++; $display("FAIL abort_pins: got sclk=%b lock=%b sdo=%b want 0 0 0", a_sclk, a_lock, a_sdo); end
    tests_run++; if (a_wr_ready !== 1'b1 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_state: got rdy=%b busy=%b want 1 0", a_wr_ready, a_busy); end
    tests_run++; if (a_oe_n !== 1'b1 || a_rd_data !== 16'h0) begin tests_failed++; $display("FAIL abort_regs: got oe_n=%b rd=%h want 1 0000", a_oe_n, a_rd_data); end
    for (int k = 0; k < 2 * LAT_A; k++) step();
    tests_run++; if (a_lock_pulses != pulses_before) begin tests_failed++; $display("FAIL abort_no_lock: got %0d pulses want %0d", a_lock_pulses, pulses_before); end
    w2 = 16'($urandom);
    write_a(w2);
    tests_run++; if (a_lat != LAT_A) begin tests_failed++; $display("FAIL after_abort_latency: got %0d want %0d", a_lat, LAT_A); end
    tests_run++; if (a_q !== w2) begin tests_failed++; $display("FAIL after_abort_q: got %h want %h", a_q, w2); end
    tests_run++; if (a_rd_data !== a_snap) begin tests_failed++; $display("FAIL after_abort_rd: got %h want %h", a_rd_data, a_snap); end
    a_prev = w2;
  endtask

  task automatic test_refresh();
    logic [47:0] w, w2;
    int n, pulses;
    w = 48'h0123456789AB;
    b_wr_data  = w;
    b_wr_valid = 1'b1;
    n = 0;
    while (b_wr_ready !== 1'b1 && n < 2000) begin step(); n++; end
    step();
    b_wr_valid = 1'b0;
    n = 1;
    while (b_done !== 1'b1 && n < 2000) begin step(); n++; end
    tests_run++; if (n != LAT_B) begin tests_failed++; $display("FAIL refresh_first_latency: got %0d want %0d", n, LAT_B); end
    tests_run++; if (b_q !== w || b_rd_data !== 48'h0) begin tests_failed++; $display("FAIL refresh_first: got q=%h rd=%h want %h 0", b_q, b_rd_data, w); end
    pulses = b_lock_pulses;
    n = 0;
    while (b_busy !== 1'b1 && n < 2000) begin step(); n++; end
    tests_run++; if (n != 11) begin tests_failed++; $display("FAIL refresh_start: busy after %0d cycles want 11", n); end
    tests_run++; if (b_wr_ready !== 1'b0) begin tests_failed++; $display("FAIL refresh_ready: got %b want 0", b_wr_ready); end
    while (b_done !== 1'b1 && n < 4000) begin step(); n++; end
    tests_run++; if (n != 10 + LAT_B) begin tests_failed++; $display("FAIL refresh_done_gap: got %0d want %0d", n, 10 + LAT_B); end
    tests_run++; if (b_rd_data !== w || b_q !== w) begin tests_failed++; $display("FAIL refresh_data: got rd=%h q=%h want %h", b_rd_data, b_q, w); end
    tests_run++; if (b_lock_pulses != pulses + 1) begin tests_failed++; $display("FAIL refresh_lock: got %0d pulses want %0d", b_lock_pulses, pulses + 1); end
    // host write presented exactly when the timer expires must win
    for (int k = 0; k < 10; k++) step();
    w2 = {16'($urandom), 32'($urandom)};
    b_wr_data  = w2;
    b_wr_valid = 1'b1;
    step();
    b_wr_valid = 1'b0;
    n = 1;
    while (b_done !== 1'b1 && n < 2000) begin step(); n++; end
    tests_run++; if (n != LAT_B) begin tests_failed++; $display("FAIL host_wins_latency: got %0d want %0d", n, LAT_B); end
    tests_run++; if (b_q !== w2 || b_rd_data !== w) begin tests_failed++; $display("FAIL host_wins_data: got q=%h rd=%h want %h %h", b_q, b_rd_data, w2, w); end
    b_sclr = 1'b1;
    step();
    b_sclr = 1'b0;
  endtask

`ifdef HC595_LOOPBACK_CHECK_EN
  task automatic write_c(input logic [7:0] w);
    int n;
    c_wr_data  = w;
    c_wr_valid = 1'b1;
    n = 0;
    while (c_wr_ready !== 1'b1 && n < 2000) begin step(); n++; end
    step();
    c_wr_valid = 1'b0;
    n = 0;
    while (c_done !== 1'b1 && n < 2000) begin step(); n++; end
  endtask

  task automatic test_loopback();
    write_c(8'h00);
    tests_run++; if (c_chk !== 1'b0) begin tests_failed++; $display("FAIL chk_first: got %b want 0", c_chk); end
    write_c(8'hFF);
    tests_run++; if (c_chk !== 1'b0) begin tests_failed++; $display("FAIL chk_second: got %b want 0", c_chk); end
    write_c(8'($urandom));
    tests_run++; if (c_chk !== 1'b1) begin tests_failed++; $display("FAIL chk_third: got %b want 1", c_chk); end
    for (int k = 0; k < 20; k++) step();
    tests_run++; if (c_chk !== 1'b1) begin tests_failed++; $display("FAIL chk_sticky: got %b want 1", c_chk); end
    c_sclr = 1'b1;
    step();
    c_sclr = 1'b0;
    tests_run++; if (c_chk !== 1'b0) begin tests_failed++; $display("FAIL chk_clear: got %b want 0", c_chk); end
    tests_run++; if (a_chk !== 1'b0) begin tests_failed++; $display("FAIL chk_a_clean: got %b want 0", a_chk); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_refresh();
`ifdef HC595_LOOPBACK_CHECK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
